// File: rtl/mul40_seq_pkg.sv
// Shared day-2 arithmetic definitions: operand widths common to the divider and
// multiplier, plus the multiplier's control states.
package mul40_seq_pkg;

    localparam int DIV_A_W = 40;
    localparam int DIV_B_W = 41;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

endpackage

// File: rtl/mul40_seq.sv
// Radix-2 shift-add multiplier: one multiplicand bit per cycle, start/done pulse
// handshake, and a same-edge shortcut when either operand is zero.
module mul40_seq
    import mul40_seq_pkg::*;
#(
    parameter int A_W = DIV_A_W,
    parameter int B_W = DIV_B_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [A_W-1:0]       a,
    input  logic [B_W-1:0]       b,
    output logic [A_W+B_W-1:0]   product,
    output logic                 ovf,
    output logic                 busy,
    output logic                 done
);

    localparam int P_W   = A_W + B_W;
    localparam int CNT_W = $clog2(A_W + 1);

    state_t             r_state;
    logic [A_W-1:0]     r_a;
    logic [P_W-1:0]     r_b;
    logic [P_W-1:0]     r_acc;
    logic [CNT_W-1:0]   r_count;
    logic [P_W-1:0]     r_product;
    logic               r_ovf;
    logic               r_busy;
    logic               r_done;

    // NOTE: all state is clocked with non-blocking assignments so every branch
    // reads the pre-edge values, which the add-then-shift step relies on.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_acc     <= '0;
            r_count   <= '0;
            r_product <= '0;
            r_ovf     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        if (a != '0 && b != '0) begin
                            r_a     <= a;
                            r_b     <= P_W'(b);
                            r_acc   <= '0;
                            r_count <= CNT_W'(A_W);
                            r_busy  <= 1'b1;
                            r_state <= RUN;
                        end else begin
                            // Zero operand: answer immediately without entering RUN.
                            r_product <= '0;
                            r_ovf     <= 1'b0;
                            r_done    <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (r_a[0]) begin
                        r_acc <= r_acc + r_b;
                    end
                    r_a     <= r_a >> 1;
                    r_b     <= r_b << 1;
                    r_count <= r_count - CNT_W'(1);
                    if (r_count == CNT_W'(1)) begin
                        r_state <= FIN;
                    end
                end
                FIN: begin
                    r_product <= r_acc;
                    r_ovf     <= (r_acc[P_W-1:A_W] != '0);
                    r_done    <= 1'b1;
                    r_busy    <= 1'b0;
                    r_state   <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign product = r_product;
    assign ovf     = r_ovf;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule

// File: tb/tb_mul40_seq.sv
// Self-checking bench for mul40_seq: directed cases plus random operands checked
// against plain wide-integer multiplication.
module tb_mul40_seq;

    localparam int AW  = 40;
    localparam int BW  = 41;
    localparam int PW  = AW + BW;
    localparam int LAT = AW + 2;   // negedges from accept to the done cycle

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] a;
    logic [BW-1:0] b;
    logic [PW-1:0] product;
    logic          ovf;
    logic          busy;
    logic          done;

    int n_checks = 0;
    int n_errors = 0;

    mul40_seq dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .a       (a),
        .b       (b),
        .product (product),
        .ovf     (ovf),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [PW-1:0] obs, input logic [PW-1:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle start from the current negedge; returns at the next negedge.
    task automatic issue(input logic [AW-1:0] ia, input logic [BW-1:0] ib);
        a     = ia;
        b     = ib;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic start_op(input logic [AW-1:0] ia, input logic [BW-1:0] ib);
        @(negedge clk);
        issue(ia, ib);
    endtask

    // Waits for done starting from negedge index n0 after accept; checks latency.
    task automatic wait_done(input string tag, input int n0, input int exp_lat);
        int n;
        n = n0;
        while (done !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ".latency"}, PW'(n), PW'(exp_lat));
    endtask

    task automatic chk_result(input string tag, input logic [AW-1:0] ia, input logic [BW-1:0] ib);
        logic [PW-1:0] e;
        e = PW'(ia) * PW'(ib);
        chk({tag, ".product"}, product, e);
        chk({tag, ".ovf"}, PW'(ovf), PW'((e >> AW) != 0));
        chk({tag, ".busy_at_done"}, PW'(busy), '0);
    endtask

    task automatic full_op(input string tag, input logic [AW-1:0] ia, input logic [BW-1:0] ib);
        int lat;
        lat = (ia == 0 || ib == 0) ? 1 : LAT;
        start_op(ia, ib);
        chk({tag, ".busy_after_accept"}, PW'(busy), PW'(lat != 1));
        wait_done(tag, 1, lat);
        chk_result(tag, ia, ib);
        @(negedge clk);
        chk({tag, ".done_one_cycle"}, PW'(done), '0);
    endtask

    initial begin
        logic [AW-1:0] ra;
        logic [BW-1:0] rb;
        int            done_seen;

        rst   = 1'b1;
        start = 1'b0;
        a     = '0;
        b     = '0;
        repeat (3) @(negedge clk);
        chk("reset.product", product, '0);
        chk("reset.ovf", PW'(ovf), '0);
        chk("reset.busy", PW'(busy), '0);
        chk("reset.done", PW'(done), '0);
        rst = 1'b0;

        full_op("small_3x5", 40'd3, 41'd5);
        chk("small_3x5.literal", product, 81'd15);

        full_op("div_check", 40'd123456789, 41'd1001);
        chk("div_check.literal", product, 81'd123580245789);
        chk("div_check.quotient", product / 81'd1001, 81'd123456789);

        full_op("max", 40'hFF_FFFF_FFFF, 41'h1FF_FFFF_FFFF);
        chk("max.literal", product, 81'h1FFFFFFFFFD0000000001);
        chk("max.ovf_literal", PW'(ovf), 81'd1);

        // Zero shortcut: previous product is nonzero, so clearing is observable.
        full_op("zero_a", 40'd0, 41'd7);
        full_op("zero_b", 40'd9, 41'd0);

        for (int i = 0; i < 8; i++) begin
            ra = AW'({$urandom(), $urandom()});
            rb = BW'({$urandom(), $urandom()});
            if (i == 3) ra = AW'($urandom_range(1, 255));
            full_op($sformatf("rand%0d", i), ra, rb);
        end

        // Start pulse while busy must be ignored.
        start_op(40'd1000003, 41'd77777);
        repeat (8) @(negedge clk);
        issue(40'd11, 41'd13);
        wait_done("ignore_busy", 10, LAT);
        chk_result("ignore_busy", 40'd1000003, 41'd77777);

        // Back-to-back: start during the done cycle.
        issue(40'd2, 41'd2);
        chk("b2b.busy", PW'(busy), 81'd1);
        chk("b2b.product_held", product, PW'(40'd1000003) * PW'(41'd77777));
        wait_done("b2b", 1, LAT);
        chk_result("b2b", 40'd2, 41'd2);
        chk("b2b.literal", product, 81'd4);

        // Reset mid-operation aborts with no done.
        start_op(40'hAB_CDEF_0123, 41'h155_5555_5555);
        repeat (18) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort.busy", PW'(busy), '0);
        chk("abort.product", product, '0);
        chk("abort.ovf", PW'(ovf), '0);
        chk("abort.done", PW'(done), '0);
        rst = 1'b0;
        done_seen = 0;
        repeat (60) begin
            @(negedge clk);
            if (done === 1'b1) done_seen++;
        end
        chk("abort.no_done", PW'(done_seen), '0);

        full_op("after_reset", 40'd6, 41'd7);
        chk("after_reset.literal", product, 81'd42);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mul40_seq.md
Name: mul40_seq

Overview:
- Sequential radix-2 shift-add multiplier with a single-pulse start/done handshake.
- Inverse of the day-2 divider: it rebuilds candidate values as quotient × divisor, for example to reconstruct repeated-digit IDs or check a division result.
- Sits beside the divider in the day-2 arithmetic datapath and is driven by the same control FSM.
- One operand bit is processed per cycle, giving fixed latency except for the zero-operand shortcut.

Parameters:
- A_W, 40: multiplicand width. Sets the iteration count.
- B_W, 41: multiplier width.
- P_W, A_W+B_W (81): product width. Derived; do not override.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- start  in  1  request pulse. Sampled only while busy=0.
- a  in  A_W  multiplicand. Captured on the accepted start edge.
- b  in  B_W  multiplier. Captured on the accepted start edge.
- product  out  P_W  registered result. Held until the next completion.
- ovf  out  1  registered with product. High when product[P_W-1:A_W] != 0, i.e. the result does not fit in A_W bits.
- busy  out  1  high while an operation is in flight.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (rst=1 at an edge):
  - product=0, ovf=0, busy=0, done=0, iteration count=0.
  - Any in-flight operation is aborted; no done is produced for it.
- States: IDLE, RUN, FIN.
- IDLE:
  - done is driven low.
  - On start=1 with a!=0 and b!=0 (accept edge E0):
    - latch a and b into internal registers; clear the accumulator.
    - set count=A_W, busy=1, and go to RUN.
  - On start=1 with a==0 or b==0 (zero shortcut):
    - product=0, ovf=0, done=1 at edge E0.
    - busy stays 0 and the state stays IDLE.
  - Operand changes after E0 have no effect.
- RUN (one edge per iteration):
  - If the current low multiplicand bit is 1, add the shifted multiplier into the P_W-bit accumulator.
  - Shift the multiplicand right and the multiplier left, each by one bit.
  - Decrement count.
  - When count reaches 0 after the A_W-th iteration (edge E0+A_W), go to FIN.
- FIN (edge E0+A_W+1):
  - product ← accumulator; ovf ← (accumulator[P_W-1:A_W] != 0).
  - done=1, busy=0, return to IDLE.
- Latency:
  - Normal path: done is high for exactly the cycle after edge E0+A_W+1 (41 edges after accept for the defaults).
  - Zero shortcut: done is high for the cycle after E0.
- start while busy=1: ignored. It is not queued and has no effect on the running operation.
- start during the done cycle: accepted, since busy=0 then; this gives back-to-back operation. product and ovf keep the old result until the new FIN.
- Arithmetic:
  - Unsigned; the accumulator is P_W bits wide, so no truncation is possible.
  - The maximum product is (2^A_W−1)(2^B_W−1) and fits in P_W bits.
- rst together with start: reset wins.

Decomposition:
- Shared package (the day-2 arithmetic package):
  - width constants DIV_A_W=40 and DIV_B_W=41, shared with the divider;
  - the state enum {IDLE, RUN, FIN}.
- No sub-module. The add/shift step is a single inline expression and does not warrant splitting out.

Test Plan:
- a=3, b=5, start at E0 → busy high from E0 to E0+41; done pulse after E0+41; product=15; ovf=0.
- a=123456789, b=1001 → product=123580245789; ovf=0. Then feed the result into the divider as dividend with divisor 1001 → quotient 123456789.
- a=0xFFFFFFFFFF, b=0x1FFFFFFFFFF → product=0x1FFFFFFFFFD0000000001; ovf=1.
- Zero shortcut:
  - a=0, b=7 → done one cycle after E0; product=0; busy never asserted.
  - Repeat with a=9, b=0 → same response.
- Busy and back-to-back handling:
  - Pulse start with new operands at E0+10 → ignored; the first result is unchanged.
  - Assert start with a=2, b=2 in the done cycle → accepted; second done 41 cycles later with product=4.
- Reset and output hold:
  - Assert rst at E0+20 → no done; busy=0, product=0, ovf=0 the next cycle.
  - A subsequent start (6×7) completes normally with product=42.
